// File: rtl/sr_req_arbiter_pkg.sv
// Shared types and widths for the push-button SET/RESET arbiter.
package sr_req_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_S = 2'd1,
        GRANT_R = 2'd2
    } arb_state_e;

    localparam int unsigned DEB_W  = 8;
    localparam int unsigned HOLD_W = 4;

endpackage

// File: rtl/sr_req_arbiter_if.sv
// Button inputs and flip-flop drive signals of the SET/RESET arbiter.
interface sr_req_arbiter_if;

    logic BUT_SET_N;
    logic BUT_RST_N;
    logic CLK_SLOW;
    logic SET;
    logic RESET;
    logic STATE;
    logic BUSY;
    logic CONFLICT;

    modport master (
        output BUT_SET_N, BUT_RST_N,
        input  CLK_SLOW, SET, RESET, STATE, BUSY, CONFLICT
    );

    modport slave (
        input  BUT_SET_N, BUT_RST_N,
        output CLK_SLOW, SET, RESET, STATE, BUSY, CONFLICT
    );

endinterface

// File: rtl/sr_req_arbiter_btn_debounce.sv
// Two-flop synchronizer, tick-based debounce counter and one-shot pending flag
// for a single active-low button.
module btn_debounce
    import sr_req_arbiter_pkg::*;
#(
    parameter int unsigned DEB_TICKS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    input  logic tick,
    input  logic clr,
    output logic pend,
    output logic qual
);

    logic [1:0]       sync;
    logic [DEB_W-1:0] cnt;
    logic             pressed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '1;
        else        sync <= {sync[0], btn_n};
    end

    always_comb begin
        pressed = ~sync[1];
        qual    = pressed & tick & (cnt == DEB_W'(DEB_TICKS - 1));
    end

    // Saturating at DEB_TICKS keeps qual from firing again until release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 cnt <= '0;
        else if (!pressed)                          cnt <= '0;
        else if (tick && cnt != DEB_W'(DEB_TICKS))  cnt <= cnt + DEB_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pend <= 1'b0;
        else if (qual) pend <= 1'b1;
        else if (clr)  pend <= 1'b0;
    end

endmodule

// File: rtl/sr_req_arbiter.sv
// Debounced, round-robin SET/RESET sequencer that also supplies the divided
// flip-flop clock; each grant is held for HOLD_TICKS slow ticks.
module sr_req_arbiter
    import sr_req_arbiter_pkg::*;
#(
    parameter int unsigned DIV_W      = 12,
    parameter int unsigned DEB_TICKS  = 16,
    parameter int unsigned HOLD_TICKS = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    sr_req_arbiter_if.slave   bus
);

    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic              pend_s, pend_r, qual_s, qual_r;
    logic              clr_s, clr_r;
    arb_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              shadow_q, shadow_d;
    logic              last_r_q, last_r_d;
    logic              conflict_q;
    logic              pick_s;
    logic              hold_done;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) div_cnt <= '0;
        else        div_cnt <= div_cnt + DIV_W'(1);
    end

    always_comb tick = &div_cnt;

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_set (
        .clk   (CLK),
        .rst_n (RST_N),
        .btn_n (bus.BUT_SET_N),
        .tick  (tick),
        .clr   (clr_s),
        .pend  (pend_s),
        .qual  (qual_s)
    );

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_rst (
        .clk   (CLK),
        .rst_n (RST_N),
        .btn_n (bus.BUT_RST_N),
        .tick  (tick),
        .clr   (clr_r),
        .pend  (pend_r),
        .qual  (qual_r)
    );

    // last_r resets to 1 so SET wins the first simultaneous request.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            shadow_q   <= 1'b0;
            last_r_q   <= 1'b1;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            shadow_q   <= shadow_d;
            last_r_q   <= last_r_d;
            conflict_q <= qual_s & qual_r;
        end
    end

    // A request matching the shadow state is consumed without a grant.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        shadow_d  = shadow_q;
        last_r_d  = last_r_q;
        clr_s     = 1'b0;
        clr_r     = 1'b0;
        pick_s    = pend_s & (~pend_r | last_r_q);
        hold_done = tick & (hold_q == HOLD_W'(HOLD_TICKS - 1));
        unique case (state_q)
            IDLE: begin
                if (pick_s) begin
                    clr_s = 1'b1;
                    if (!shadow_q) state_d = GRANT_S;
                end else if (pend_r) begin
                    clr_r = 1'b1;
                    if (shadow_q) state_d = GRANT_R;
                end
            end
            GRANT_S, GRANT_R: begin
                if (hold_done) begin
                    state_d  = IDLE;
                    hold_d   = '0;
                    shadow_d = (state_q == GRANT_S);
                    last_r_d = (state_q == GRANT_R);
                end else if (tick) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.CLK_SLOW = div_cnt[DIV_W-1];
    assign bus.SET      = (state_q == GRANT_S);
    assign bus.RESET    = (state_q == GRANT_R);
    assign bus.STATE    = shadow_q;
    assign bus.BUSY     = (state_q != IDLE);
    assign bus.CONFLICT = conflict_q;

endmodule

// File: tb/tb_sr_req_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants (type, start cycle, length),
// a negedge monitor pops and compares each observed SET/RESET pulse.
module tb_sr_req_arbiter;
    import sr_req_arbiter_pkg::*;

    localparam int PER = 16;   // 2^DIV_W with DIV_W=4

    typedef struct {
        bit is_set;
        int rise;
        int dur;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc;
    int   conflict_cnt = 0;
    int   both_cnt = 0;

    sr_req_arbiter_if bus();

    sr_req_arbiter #(
        .DIV_W      (4),
        .DEB_TICKS  (3),
        .HOLD_TICKS (2)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges since reset release = divider value mod PER
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Edge index of the 3rd tick at or after edge n; SET/RESET rises 2 edges later.
    function automatic int third_tick(input int n);
        return n + (PER - 1 - (n % PER)) + 2 * PER;
    endfunction

    initial begin : monitor
        bit   in_g;
        bit   g_set;
        int   g_start;
        int   g_dur;
        exp_t e;
        in_g = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_g = 1'b0;
            end else begin
                if (bus.CONFLICT) conflict_cnt++;
                if (bus.SET && bus.RESET) both_cnt++;
                if (!in_g && (bus.SET || bus.RESET)) begin
                    in_g    = 1'b1;
                    g_set   = bus.SET;
                    g_start = cyc;
                    if (sb.size() == 0) begin
                        check("unexpected_grant_set", int'(g_set), -1);
                        g_dur = -1;
                    end else begin
                        e = sb.pop_front();
                        check("grant_type_set", int'(g_set), int'(e.is_set));
                        check("grant_start_cycle", cyc, e.rise);
                        g_dur = e.dur;
                    end
                end else if (in_g && !(g_set ? bus.SET : bus.RESET)) begin
                    in_g = 1'b0;
                    if (g_dur >= 0) check("grant_duration", cyc - g_start, g_dur);
                    check("state_after_grant", int'(bus.STATE), int'(g_set));
                    check("busy_after_grant", int'(bus.BUSY), 0);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not end, got timeout, required finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic press_set_expect(output int p);
        int m3;
        p = cyc;
        bus.BUT_SET_N = 1'b0;
        m3 = third_tick(p + 2);
        sb.push_back('{is_set: 1'b1, rise: m3 + 2, dur: 2 * PER - 1});
    endtask

    initial begin : stimulus
        int p;
        int viol;
        int c0;
        int m3;
        bit seen;

        rst_n         = 1'b0;
        bus.BUT_SET_N = 1'b1;
        bus.BUT_RST_N = 1'b1;

        // Reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_set",      int'(bus.SET),      0);
        check("rst_reset",    int'(bus.RESET),    0);
        check("rst_state",    int'(bus.STATE),    0);
        check("rst_busy",     int'(bus.BUSY),     0);
        check("rst_conflict", int'(bus.CONFLICT), 0);
        check("rst_clk_slow", int'(bus.CLK_SLOW), 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 2 * PER; k++) begin
            @(posedge clk);
            #1;
            check("clk_slow_phase", int'(bus.CLK_SLOW), int'((k % PER) >= PER / 2));
        end

        // Bounce: 5-CLK press windows never accumulate 3 ticks
        @(negedge clk);
        bus.BUT_SET_N = 1'b0;
        for (int i = 0; i < 40; i++) begin
            repeat (5) @(negedge clk);
            bus.BUT_SET_N = ~bus.BUT_SET_N;
        end
        bus.BUT_SET_N = 1'b1;
        repeat (100) @(negedge clk);
        check("bounce_busy",  int'(bus.BUSY),  0);
        check("bounce_state", int'(bus.STATE), 0);

        // Single set
        press_set_expect(p);
        repeat (100) @(negedge clk);
        bus.BUT_SET_N = 1'b1;
        repeat (20) @(negedge clk);
        check("single_state",    int'(bus.STATE), 1);
        check("single_busy",     int'(bus.BUSY),  0);
        check("single_sb_empty", sb.size(),       0);

        // Redundant set while STATE=1
        bus.BUT_SET_N = 1'b0;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.BUSY || bus.SET) viol++;
        end
        bus.BUT_SET_N = 1'b1;
        check("redundant_busy_or_set", viol, 0);
        repeat (20) @(negedge clk);
        check("redundant_state", int'(bus.STATE), 1);

        // Fresh reset, then both buttons on the same cycle
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst2_state", int'(bus.STATE), 0);
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        c0 = conflict_cnt;
        p  = cyc;
        bus.BUT_SET_N = 1'b0;
        bus.BUT_RST_N = 1'b0;
        m3 = third_tick(p + 2);
        sb.push_back('{is_set: 1'b1, rise: m3 + 2,       dur: 2 * PER - 1});
        sb.push_back('{is_set: 1'b0, rise: m3 + 2 * PER + 2, dur: 2 * PER - 1});
        repeat (200) @(negedge clk);
        bus.BUT_SET_N = 1'b1;
        bus.BUT_RST_N = 1'b1;
        repeat (20) @(negedge clk);
        check("simul_conflict_pulses", conflict_cnt - c0, 1);
        check("simul_state",           int'(bus.STATE),   0);
        check("simul_busy",            int'(bus.BUSY),    0);
        check("simul_sb_empty",        sb.size(),         0);

        // Reset asserted mid-grant
        press_set_expect(p);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.SET) seen = 1'b1;
        end
        check("midrst_set_seen", int'(seen), 1);
        #2;
        rst_n = 1'b0;
        bus.BUT_SET_N = 1'b1;
        #1;
        check("midrst_set_async", int'(bus.SET),   0);
        check("midrst_busy",      int'(bus.BUSY),  0);
        check("midrst_state",     int'(bus.STATE), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("midrst_no_regrant", int'(bus.BUSY),  0);
        check("midrst_state_end",  int'(bus.STATE), 0);

        check("set_reset_overlap", both_cnt,  0);
        check("final_sb_empty",    sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
